// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - packs a byte stream into BPW-byte words, writes them to memory, then releases the CPU.
// Optional CHECKSUM output port is present only when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader #(
  parameter int ADDR_W  = 8,
  parameter int BPW     = 4,
  parameter int NWORDS  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [8*BPW-1:0]  mem_data,
  output logic              mem_we,
  input  logic              mem_moc,
  output logic              cpu_reset,
  output logic              done,
`ifdef MEM_LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              err
);
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WT_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [BC_W-1:0]  LAST_BC  = BC_W'(BPW - 1);
  localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic [WT_W-1:0]    wait_q, wait_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [8*BPW-1:0]   data_q, data_d;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_ASSEMBLE;
          idx_d   = '0;
          bc_d    = '0;
          addr_d  = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_ASSEMBLE: begin
        if (in_valid) begin
          data_d[8*bc_q +: 8] = in_data;
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          if (bc_q == LAST_BC) begin
            // Address is latched here so it stays stable for the whole write.
            state_d = S_WRITE;
            bc_d    = '0;
            wait_d  = '0;
            addr_d  = ADDR_W'(32'(idx_q) * BPW);
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        // A completion seen in the final wait cycle takes priority over the timeout.
        if (mem_moc) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ASSEMBLE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WT_LAST) begin
            state_d = S_ERROR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bc_q    <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bc_q    <= bc_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_ASSEMBLE);
  assign mem_we    = (state_q == S_WRITE);
  assign cpu_reset = (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign checksum  = sum_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader: vector table, random loads, timeout and reset corners.
module tb_mem_loader;
  localparam int ADDR_W  = 8;
  localparam int BPW     = 4;
  localparam int NWORDS  = 2;
  localparam int TIMEOUT = 15;
  localparam int NB      = BPW * NWORDS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [8*BPW-1:0]  mem_data;
  logic              mem_we;
  logic              mem_moc = 1'b0;
  logic              cpu_reset;
  logic              done;
  logic              err;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  mem_loader #(.ADDR_W(ADDR_W), .BPW(BPW), .NWORDS(NWORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_moc(mem_moc), .cpu_reset(cpu_reset), .done(done),
`ifdef MEM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: pulses mem_moc in WRITE cycle moc_cyc (1-based, 0 = never) and logs writes.
  int moc_cyc = 2;
  bit noise = 1'b0;
  int we_cnt = 0;
  int viol = 0;
  logic [ADDR_W-1:0] hold_addr;
  logic [8*BPW-1:0]  hold_data;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [8*BPW-1:0]  wr_data[$];

  always @(negedge clk) begin
    if (!mem_we) begin
      we_cnt = 0;
      mem_moc = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end else begin
      we_cnt++;
      if (in_ready) viol++;
      if (we_cnt == 1) begin
        hold_addr = mem_addr;
        hold_data = mem_data;
      end else if (mem_addr !== hold_addr || mem_data !== hold_data) begin
        viol++;
      end
      mem_moc = (moc_cyc != 0 && we_cnt == moc_cyc);
      if (mem_moc) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_data);
      end
    end
  end

  logic [7:0] stim[NB];

  function automatic logic [8*BPW-1:0] pack_word(input int w);
    logic [8*BPW-1:0] r = '0;
    for (int k = 0; k < BPW; k++) r = r | ((8*BPW)'(stim[w*BPW + k]) << (8*k));
    return r;
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, " in_ready"}, in_ready, 0);
    chk({nm, " mem_we"}, mem_we, 0);
    chk({nm, " cpu_reset"}, cpu_reset, 1);
    chk({nm, " done/err"}, {done, err}, 0);
    chk({nm, " mem_addr"}, mem_addr, 0);
    chk({nm, " mem_data"}, mem_data, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk({nm, " checksum"}, checksum, 0);
`endif
  endtask

  task automatic pulse_start(input string nm);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " start->load"}, {done, cpu_reset, in_ready, err}, 4'b0110);
  endtask

  // mode 0: valid always, 1: valid toggles, 2: random valid plus stray start pulses.
  task automatic feed(input int n, input int mode, output bit ok);
    int idx = 0;
    int budget = 0;
    bit rdy = 1'b0;
    in_valid = 1'b0;
    while (idx < n && budget < 400) begin
      @(negedge clk);
      if (in_valid && rdy) idx++;
      rdy = in_ready;
      if (idx < n) begin
        case (mode)
          0: in_valid = 1'b1;
          1: in_valid = ~in_valid;
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_data = stim[idx];
        start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        in_valid = 1'b0;
        start = 1'b0;
      end
      budget++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    ok = (idx == n);
  endtask

  task automatic run_case(input string nm, input logic [63:0] bytes, input int mode,
                          input int mc, input bit exp_err);
    bit ok;
    int cyc;
    int nacc;
    logic [7:0] sum;
    logic [63:0] act;
    for (int i = 0; i < NB; i++) stim[i] = bytes[8*i +: 8];
    moc_cyc = mc;
    viol = 0;
    wr_addr.delete();
    wr_data.delete();
    pulse_start(nm);
    noise = (mode == 2);
    nacc = exp_err ? BPW : NB;
    feed(nacc, mode, ok);
    chk({nm, " bytes accepted"}, ok, 1);
    cyc = 0;
    while (!(done || err) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    noise = 1'b0;
    chk({nm, " done"}, done, !exp_err);
    chk({nm, " err"}, err, exp_err);
    chk({nm, " cpu_reset"}, cpu_reset, exp_err);
    chk({nm, " idle bus"}, {mem_we, in_ready}, 0);
    chk({nm, " write count"}, wr_addr.size(), exp_err ? 0 : NWORDS);
    if (!exp_err) begin
      for (int w = 0; w < NWORDS; w++) begin
        act = (w < wr_addr.size()) ? {24'h0, wr_addr[w], wr_data[w]} : 64'hx;
        chk({nm, $sformatf(" word%0d addr/data", w)}, act,
            {24'h0, ADDR_W'((w * BPW) % (1 << ADDR_W)), pack_word(w)});
      end
    end
    chk({nm, " write stable, in_ready low"}, viol, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    sum = 8'h00;
    for (int i = 0; i < nacc; i++) sum = sum + stim[i];
    chk({nm, " checksum"}, checksum, sum);
`else
    sum = 8'h00;
`endif
  endtask

  typedef struct {
    string       nm;
    logic [63:0] bytes;
    int          mode;
    int          mc;
    bit          exp_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit ok;
    int cyc;
    tbl[0] = '{"basic",     64'h0807060504030201, 0, 2,  1'b0};
    tbl[1] = '{"toggle",    64'h0807060504030201, 1, 2,  1'b0};
    tbl[2] = '{"timeout",   64'h0807060504030201, 0, 0,  1'b1};
    tbl[3] = '{"after_err", 64'h0807060504030201, 0, 2,  1'b0};
    tbl[4] = '{"moc15",     64'h0123456789ABCDEF, 0, 15, 1'b0};
    tbl[5] = '{"moc16",     64'hCAFEF00DDEADBEEF, 0, 16, 1'b1};
    tbl[6] = '{"ff02",      64'h00000000000002FF, 2, 1,  1'b0};
    tbl[7] = '{"ones",      64'hFFFFFFFFFFFFFFFF, 1, 3,  1'b0};
    tbl[8] = '{"moc1",      64'h1122334455667788, 2, 1,  1'b0};

    #12;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle hold", {cpu_reset, in_ready, mem_we, done}, 4'b1000);

    foreach (tbl[i]) run_case(tbl[i].nm, tbl[i].bytes, tbl[i].mode, tbl[i].mc, tbl[i].exp_err);

    for (int r = 0; r < 20; r++) begin
      run_case($sformatf("rand%0d", r), {$urandom, $urandom}, int'($urandom_range(0, 2)),
               int'($urandom_range(1, TIMEOUT)), 1'b0);
    end

    for (int i = 0; i < NB; i++) stim[i] = 8'(i + 1);
    moc_cyc = 2;
    wr_addr.delete();
    wr_data.delete();
    pulse_start("rst_mid");
    feed(NB, 0, ok);
    moc_cyc = 0;
    cyc = 0;
    while (!mem_we && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid in second write", {mem_we, wr_addr.size() == 1, mem_addr == ADDR_W'(BPW)}, 3'b111);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_case("reload", 64'h0807060504030201, 0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
